mux8_rr_arbiter: RTL

- Round-robin arbiter that shares one 32-bit resource port (e.g. a memory or writeback bus) between 8 requesters.
- Drives the sel input of the shared 8-way multiplexer in front of that resource, plus a one-hot grant vector back to the requesters.
- Holds each grant until the transaction completes, the owner drops its request, or a hold timeout expires.
- Prevents starvation with a rotating priority pointer.

---
 rtl/mux8_rr_arbiter_if.sv | 24 ++
 rtl/mux8_rr_arbiter.sv | 131 +++++++++++++
 2 files changed

// File: rtl/mux8_rr_arbiter_if.sv
// Request/grant bundle between the eight requesters, the shared resource and the arbiter.
// The arbiter takes the slave view; the requester/resource side takes the master view.
interface mux8_rr_arbiter_if;
  // Handshake: req_i[k] is held by requester k until it sees grant_o[k]. It stays
  // high for as long as the requester wants the resource. done_i is a one-cycle
  // completion strobe for the current owner's transaction. grant_o, sel_o, busy_o
  // and timeout_o are registered and change only on clock edges.
  logic [7:0] req_i;
  logic       done_i;
  logic [7:0] grant_o;
  logic [2:0] sel_o;
  logic       busy_o;
  logic       timeout_o;

  modport master (
    output req_i, done_i,
    input  grant_o, sel_o, busy_o, timeout_o
  );

  modport slave (
    input  req_i, done_i,
    output grant_o, sel_o, busy_o, timeout_o
  );
endinterface

// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter for one shared 32-bit port across 8 requesters, with a hold timeout.
// All outputs are registered, and ownership hands over with no idle bubble.
module mux8_rr_arbiter #(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 5
) (
  input  logic                clk_i,
  input  logic                rst_i,
  mux8_rr_arbiter_if.slave    bus,
  output logic                state_dbg
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  // Saturation point of the hold counter; with the timeout disabled it saturates at all-ones.
  localparam logic [CNT_W-1:0] CNT_SAT = (MAX_HOLD == 0) ? {CNT_W{1'b1}} : CNT_W'(MAX_HOLD);

  state_t           state_q, state_n;
  logic [7:0]       grant_q, grant_n;
  logic [2:0]       sel_q, sel_n;
  logic             busy_q, busy_n;
  logic             tout_q, tout_n;
  logic [CNT_W-1:0] cnt_q, cnt_n;
  logic [2:0]       ptr_q, ptr_n;

  logic [7:0] owner_bit;
  logic       owner_req;
  logic       by_limit;
  logic       tout_only;
  logic       release_c;
  logic [3:0] idle_win;
  logic [3:0] busy_win;

  // Returns {found, index} of the first set bit scanning start, start+1, ... mod 8.
  function automatic logic [3:0] pick(input logic [7:0] req, input logic [2:0] start);
    logic [3:0] res;
    logic [2:0] idx;
    res = 4'd0;
    for (int i = 7; i >= 0; i--) begin
      idx = start + 3'(i);
      if (req[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      grant_q <= 8'd0;
      sel_q   <= 3'd0;
      busy_q  <= 1'b0;
      tout_q  <= 1'b0;
      cnt_q   <= '0;
      ptr_q   <= 3'd0;
    end else begin
      state_q <= state_n;
      grant_q <= grant_n;
      sel_q   <= sel_n;
      busy_q  <= busy_n;
      tout_q  <= tout_n;
      cnt_q   <= cnt_n;
      ptr_q   <= ptr_n;
    end
  end

  always_comb begin
    state_n   = state_q;
    grant_n   = grant_q;
    sel_n     = sel_q;
    busy_n    = busy_q;
    tout_n    = 1'b0;
    cnt_n     = cnt_q;
    ptr_n     = ptr_q;
    owner_bit = 8'b1 << sel_q;
    owner_req = |(bus.req_i & owner_bit);
    by_limit  = (MAX_HOLD != 0) && (cnt_q == CNT_SAT);
    // The counter limit counts as a timeout only when nothing else ends the grant.
    tout_only = by_limit && !bus.done_i && owner_req;
    release_c = bus.done_i || !owner_req || by_limit;
    idle_win  = pick(bus.req_i, ptr_q);
    busy_win  = pick(bus.req_i & ~owner_bit, sel_q + 3'd1);

    case (state_q)
      IDLE: begin
        if (idle_win[3]) begin
          grant_n = 8'b1 << idle_win[2:0];
          sel_n   = idle_win[2:0];
          busy_n  = 1'b1;
          cnt_n   = CNT_W'(1);
          state_n = BUSY;
        end else begin
          grant_n = 8'd0;
          busy_n  = 1'b0;
        end
      end
      BUSY: begin
        if (!release_c) begin
          cnt_n = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + CNT_W'(1);
        end else begin
          ptr_n  = sel_q + 3'd1;
          tout_n = tout_only;
          if (busy_win[3]) begin
            grant_n = 8'b1 << busy_win[2:0];
            sel_n   = busy_win[2:0];
            cnt_n   = CNT_W'(1);
          end else if (owner_req && !tout_only) begin
            cnt_n = CNT_W'(1);
          end else begin
            // A timed-out sole requester sits out one idle cycle before it can win again.
            grant_n = 8'd0;
            busy_n  = 1'b0;
            cnt_n   = '0;
            state_n = IDLE;
          end
        end
      end
      default: begin
        state_n = IDLE;
        grant_n = 8'd0;
        busy_n  = 1'b0;
      end
    endcase
  end

  assign bus.grant_o   = grant_q;
  assign bus.sel_o     = sel_q;
  assign bus.busy_o    = busy_q;
  assign bus.timeout_o = tout_q;
  assign state_dbg     = (state_q == BUSY);

endmodule
